// File: rtl/psrv32_pkg.sv
// Shared constants and types for the psrv32 RV32M multiply/divide unit.
// Holds XLEN, opcode/funct7 match values, funct3 op codes and the FSM enum.
package psrv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// D/E-side operand bundle and result/stall bundle of the muldiv unit.
// master: pipeline side (drives de_*, flush_i); slave: the muldiv unit.
interface execute_muldiv_unit_if;
  import psrv32_pkg::*;

  logic [6:0]      de_opcode_i;
  logic [2:0]      de_funct3_i;
  logic [6:0]      de_funct7_i;
  logic [4:0]      de_rd_i;
  logic [XLEN-1:0] de_read_data1_i;
  logic [XLEN-1:0] de_read_data2_i;
  logic            flush_i;
  logic            md_stall_o;
  logic            md_busy_o;
  logic            md_valid_o;
  logic [XLEN-1:0] md_result_o;
  logic [4:0]      md_rd_o;

  modport master (
    output de_opcode_i, de_funct3_i, de_funct7_i, de_rd_i,
    output de_read_data1_i, de_read_data2_i, flush_i,
    input  md_stall_o, md_busy_o, md_valid_o, md_result_o, md_rd_o
  );

  modport slave (
    input  de_opcode_i, de_funct3_i, de_funct7_i, de_rd_i,
    input  de_read_data1_i, de_read_data2_i, flush_i,
    output md_stall_o, md_busy_o, md_valid_o, md_result_o, md_rd_o
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: 2*XLEN accumulator, step counter, shift-add / restoring divide.
// Ports: load_i/step_i control, div_i mode, a_i/b_i magnitudes, acc_nxt_o, last_o.
module muldiv_iter_core
  import psrv32_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_nxt_o,
  output logic              last_o
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt;
  logic              div_q;

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  logic          ge;

  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    sh   = acc[2*XLEN-1:XLEN-1];
    diff = sh - {1'b0, b_q};
    ge   = ~diff[XLEN];
    if (div_q)
      acc_nxt_o = {(ge ? diff[XLEN-1:0] : sh[XLEN-1:0]),
                   acc[XLEN-2:0], ge};
    else
      acc_nxt_o = {sum, acc[XLEN-1:1]};
  end

  assign last_o = (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc   <= {{XLEN{1'b0}}, a_i};
      b_q   <= b_i;
      cnt   <= '0;
      div_q <= div_i;
    end else if (step_i) begin
      acc <= acc_nxt_o;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// RV32M multiply/divide unit for the execute stage: FSM, signs, special cases, stall.
// Ports: clk_i, reset_i, bus (slave). Define PSRV32_FAST_MUL_EN for 1-cycle multiply.
module execute_muldiv_unit
  import psrv32_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  execute_muldiv_unit_if.slave bus
);

  md_state_e state;

  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            rneg_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      md_rd_q;

  logic [2:0]      f3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            match;
  logic            start;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;

  logic [2*XLEN-1:0] acc_nxt;
  logic              last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   calc_res;

  assign f3 = bus.de_funct3_i;
  assign a  = bus.de_read_data1_i;
  assign b  = bus.de_read_data2_i;

  assign match = (bus.de_opcode_i == OPCODE_OP) &&
                 (bus.de_funct7_i == FUNCT7_MULDIV);
  assign start = (state == IDLE) && match && !bus.flush_i;

  always_comb begin
    is_div   = f3[2];
    a_signed = (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    b_signed = (f3 == F3_MULH) || (f3 == F3_DIV) ||
               (f3 == F3_REM);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    div_zero = is_div && (b == '0);
    ovf      = ((f3 == F3_DIV) || (f3 == F3_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || ovf;
    // f3[1] separates REM/REMU from DIV/DIVU
    if (div_zero)
      spec_res = f3[1] ? a : '1;
    else
      spec_res = f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    if (op_q[2])
      calc_res = op_q[1] ? (rneg_q ? -rem : rem)
                         : (neg_q  ? -quo : quo);
    else if (op_q == F3_MUL)
      calc_res = prod[XLEN-1:0];
    else
      calc_res = prod[2*XLEN-1:XLEN];
  end

`ifdef PSRV32_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  logic [2*XLEN-1:0] fsprod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fprod  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fsprod = (sa ^ sb) ? -fprod : fprod;
    fast_res = (f3 == F3_MUL) ? fsprod[XLEN-1:0]
                              : fsprod[2*XLEN-1:XLEN];
  end
`endif

  muldiv_iter_core u_core (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (start),
    .step_i    (state == CALC),
    .div_i     (is_div),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      md_rd_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            op_q   <= f3;
            rd_q   <= bus.de_rd_i;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            if (special) begin
              result_q <= spec_res;
              md_rd_q  <= bus.de_rd_i;
              valid_q  <= 1'b1;
              state    <= DONE;
`ifdef PSRV32_FAST_MUL_EN
            end else if (!is_div) begin
              result_q <= fast_res;
              md_rd_q  <= bus.de_rd_i;
              valid_q  <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else if (last) begin
            result_q <= calc_res;
            md_rd_q  <= rd_q;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.md_stall_o  = !reset_i && (start || (state == CALC));
  assign bus.md_busy_o   = (state != IDLE);
  assign bus.md_valid_o  = valid_q && !bus.flush_i;
  assign bus.md_result_o = result_q;
  assign bus.md_rd_o     = md_rd_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: directed RV32M vectors.
// Stimulus pushes expected {rd,result}; a negedge monitor pops on md_valid_o.
module tb_execute_muldiv_unit;
  import psrv32_pkg::*;

`ifdef PSRV32_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  logic clk;
  logic reset_i;
  int   checks;
  int   errors;
  exp_t sb[$];

  execute_muldiv_unit_if bus ();

  execute_muldiv_unit dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.md_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid act=%h exp=none",
                 bus.md_result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.md_result_o, e.res);
        chk("rd", {27'd0, bus.md_rd_o}, {27'd0, e.rd});
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.de_opcode_i     = OPCODE_OP;
    bus.de_funct7_i     = FUNCT7_MULDIV;
    bus.de_funct3_i     = f3;
    bus.de_rd_i         = rd;
    bus.de_read_data1_i = a;
    bus.de_read_data2_i = b;
  endtask

  task automatic idle_bus();
    bus.de_opcode_i = 7'd0;
    bus.de_funct7_i = 7'd0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] res, input int lat);
    int   seen;
    logic bad;
    exp_t e;
    @(posedge clk);
    #1;
    drive(f3, a, b, rd);
    e.rd  = rd;
    e.res = res;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_T", {31'd0, bus.md_stall_o}, 32'd1);
    seen = 0;
    bad  = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.md_valid_o) begin
        seen = k;
        break;
      end
      if (bus.md_stall_o !== 1'b1) bad = 1'b1;
    end
    if (seen == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout act=none exp=valid");
    end
    chk("latency", seen, lat);
    chk("stall_done", {31'd0, bus.md_stall_o}, 32'd0);
    chk("stall_window", {31'd0, bad}, 32'd0);
    idle_bus();
  endtask

  initial begin
    int nvalid;
    checks  = 0;
    errors  = 0;
    reset_i = 1'b1;
    idle_bus();
    bus.de_funct3_i     = 3'd0;
    bus.de_rd_i         = 5'd0;
    bus.de_read_data1_i = '0;
    bus.de_read_data2_i = '0;
    bus.flush_i         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, bus.md_stall_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.md_busy_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.md_valid_o}, 32'd0);
    chk("rst_result", bus.md_result_o, 32'd0);
    chk("rst_rd", {27'd0, bus.md_rd_o}, 32'd0);
    reset_i = 1'b0;

    run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, MUL_LAT);
    run_op(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,
           32'hFFFFFFFE, MUL_LAT);
    run_op(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,
           32'h00000000, MUL_LAT);
    run_op(F3_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd8,
           32'hFFFFFFFF, MUL_LAT);
    run_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, DIV_LAT);
    run_op(F3_REM, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, DIV_LAT);
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, DIV_LAT);
    run_op(F3_REMU, 32'd100, 32'd7, 5'd12, 32'd2, DIV_LAT);
    run_op(F3_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1);
    run_op(F3_REM, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd15,
           32'h80000000, 1);
    run_op(F3_REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 1);
    run_op(F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, MUL_LAT);
    run_op(F3_DIV, 32'h80000000, 32'd2, 5'd17, 32'hC0000000, DIV_LAT);

    // flush a DIV in flight at T+10
    @(posedge clk);
    #1;
    drive(F3_DIV, 32'd1000, 32'd3, 5'd20);
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    idle_bus();
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    chk("flush_stall", {31'd0, bus.md_stall_o}, 32'd0);
    chk("flush_busy", {31'd0, bus.md_busy_o}, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.md_valid_o) nvalid++;
    end
    chk("flush_novalid", nvalid, 0);
    run_op(F3_MUL, 32'h00012345, 32'h00000100, 5'd21,
           32'h01234500, MUL_LAT);

    // reset mid-op at T+5 with the instruction still presented
    @(posedge clk);
    #1;
    drive(F3_DIVU, 32'd100, 32'd7, 5'd22);
    repeat (5) @(posedge clk);
    #1;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, bus.md_stall_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.md_busy_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.md_valid_o}, 32'd0);
    chk("mid_rst_result", bus.md_result_o, 32'd0);
    chk("mid_rst_rd", {27'd0, bus.md_rd_o}, 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    reset_i = 1'b0;
    run_op(F3_REMU, 32'd100, 32'd7, 5'd23, 32'd2, DIV_LAT);

    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Multi-cycle RV32M multiply/divide unit in the execute stage of the 5-stage pipeline, consuming the decode/execute pipeline register outputs. It recognises M-extension instructions and runs them iteratively. While an operation is in flight it stalls the front end, holding the PC, IF/ID and D/E registers. It then presents a one-cycle-valid result to the execute-stage result mux.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- de_opcode_i  in  7  opcode from D/E register
- de_funct3_i  in  3  M-op select
- de_funct7_i  in  7  instruction[31:25] from D/E register
- de_rd_i  in  5  destination register
- de_read_data1_i  in  XLEN  rs1 operand (already forwarded)
- de_read_data2_i  in  XLEN  rs2 operand (already forwarded)
- flush_i  in  1  kill the in-flight op (branch/jump redirect)
- md_stall_o  out  1  hold PC, IF/ID and D/E registers
- md_busy_o  out  1  state is not IDLE
- md_valid_o  out  1  result valid, exactly one cycle per op
- md_result_o  out  XLEN  result
- md_rd_o  out  5  destination of md_result_o

## Operation
- Match: de_opcode_i==7'b0110011 && de_funct7_i==7'b0000001.
- funct3 ops: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States:
  - IDLE: on match and !flush_i, latch operands, rd, op and signs → CALC, or → DONE for special cases.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes; step counter 0..XLEN-1; after step XLEN-1 apply sign correction and register the result → DONE.
  - DONE: md_valid_o=1 for one cycle, then → IDLE.
- Multiply: 2·XLEN-bit product of magnitudes, negated if operand signs differ (sign taken per MULH/MULHSU/MULHU rules). MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide: quotient is negated if signs differ; remainder takes the dividend's sign.
- Special cases (IDLE → DONE directly):
  - divisor 0: quotient all-ones, remainder = dividend.
  - signed overflow (-2^(XLEN-1) / -1): quotient -2^(XLEN-1), remainder 0.
- rd==x0 still executes and asserts valid, with md_rd_o=0; writeback ignores it.
- flush_i in CALC or DONE: → IDLE next cycle, md_valid_o suppressed.
- flush_i in IDLE: no start.
- Reset, including mid-op: state IDLE; all outputs 0.

## Timing
- Start cycle T (IDLE with match): md_stall_o=1 combinationally.
- Iterative path: CALC occupies T+1..T+XLEN. md_stall_o=1 for T..T+XLEN. DONE at T+XLEN+1, with md_valid_o=1 and md_stall_o=0.
- Special cases and fast multiply: DONE at T+1; stall is asserted in T only.
- In DONE the D/E register advances at the end of the cycle. The same instruction therefore never restarts: IDLE is re-entered with the next instruction.
- md_result_o and md_rd_o are registered and stable from DONE until the next DONE. They are 0 after reset.
- md_busy_o=1 in CALC and DONE.
- Back-to-back M ops: the second starts in the cycle after DONE.

## Configuration
- PSRV32_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle XLEN×XLEN multiplier, IDLE → DONE, latency 1. Division stays iterative.
- Undefined: all multiplies use the iterative CALC path with XLEN+1-cycle latency, and no hardware multiplier is inferred.

## Structure
- Shared package psrv32_pkg holds:
  - OPCODE_OP (7'b0110011), FUNCT7_MULDIV (7'b0000001)
  - funct3 constants F3_MUL..F3_REMU
  - the muldiv state enum (IDLE, CALC, DONE)
- One sub-module, muldiv_iter_core, holds the shared 2·XLEN accumulator, the step counter and the add/subtract datapath. The top level holds the FSM, special-case detection, sign handling and stall logic.

## Test plan
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB. Stall is high T..T+32 and valid at T+33; with PSRV32_FAST_MUL_EN, valid at T+1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each valid at T+1 with a 1-cycle stall.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, each valid at T+1.
- flush_i at T+10 → no valid pulse, stall low from T+11, and the next MUL completes correctly. reset_i asserted at T+5 → all outputs 0 immediately and state IDLE.
